// File: rtl/exu_div_pkg.sv
// Shared types and helpers for the iterative RV32M divider (exu_div_iter).
// Holds the FSM state enum, the one-hot op bit positions and the
// negate / conditional-negate / one-hot helpers used at launch and completion.
package exu_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Bit positions inside the one-hot op vector {remu, rem, divu, div}
  localparam int OP_DIV  = 0;
  localparam int OP_DIVU = 1;
  localparam int OP_REM  = 2;
  localparam int OP_REMU = 3;

  // Helpers work on a wide container; callers zero-extend in and truncate out,
  // which keeps two's-complement results correct for any width up to this.
  localparam int HELPER_W = 64;

  function automatic logic [HELPER_W-1:0] negate(input logic [HELPER_W-1:0] x);
    return -x;
  endfunction

  // Two's-complement absolute value when neg is the operand's sign bit
  function automatic logic [HELPER_W-1:0] cond_negate(input logic [HELPER_W-1:0] x,
                                                      input logic                neg);
    return neg ? negate(x) : x;
  endfunction

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One combinational radix-2 restoring-division iteration.
// Shifts {rem, quo} left by one, trial-subtracts the divisor from the
// partial remainder and sets the new quotient bit from the trial sign.
module div_restore_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem_i,
  input  logic [DATA_WIDTH-1:0] quo_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic [DATA_WIDTH-1:0] rem_o,
  output logic [DATA_WIDTH-1:0] quo_o
);

  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] trial;

  assign shifted = {rem_i, quo_i[DATA_WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor_i};

  // Keep the trial difference only when it did not go negative
  always_comb begin
    if (!trial[DATA_WIDTH]) begin
      rem_o = trial[DATA_WIDTH-1:0];
      quo_o = {quo_i[DATA_WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[DATA_WIDTH-1:0];
      quo_o = {quo_i[DATA_WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/exu_div_iter.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Magnitudes are divided unsigned over DATA_WIDTH cycles, then the quotient
// and remainder signs are re-applied. Result is registered and strobed by a
// one-cycle valid_o in DONE; busy_o covers CALC and DONE.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip
// CALC and complete in DONE on the cycle after launch.
module exu_div_iter
  import exu_div_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  input  logic [3:0]            op_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  busy_o,
  output logic                  valid_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

  div_state_e state_q, state_d;

  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [DATA_WIDTH-1:0] rem_q, quo_q, dvs_q, result_q;
  logic                  rem_sel_q, qneg_q, rneg_q, dz_q;

  logic signed [DATA_WIDTH-1:0] dividend_s, divisor_s;
  logic                  launch, signed_op, rem_sel_in, dvd_neg, dvs_neg, dz_in;
  logic [DATA_WIDTH-1:0] dvd_mag, dvs_mag;
  logic [DATA_WIDTH-1:0] rem_nxt, quo_nxt, fin_quo, fin_rem, fin_res;
  logic                  early;
  logic [DATA_WIDTH-1:0] early_res;

  assign dividend_s = dividend_i;
  assign divisor_s  = divisor_i;

  assign launch     = (state_q == IDLE) && start_i && !flush_i && is_onehot4(op_i);
  assign signed_op  = op_i[OP_DIV] | op_i[OP_REM];
  assign rem_sel_in = op_i[OP_REM] | op_i[OP_REMU];
  assign dvd_neg    = signed_op && (dividend_s < 0);
  assign dvs_neg    = signed_op && (divisor_s < 0);
  assign dz_in      = (divisor_i == '0);
  assign dvd_mag    = DATA_WIDTH'(cond_negate(HELPER_W'(dividend_i), dvd_neg));
  assign dvs_mag    = DATA_WIDTH'(cond_negate(HELPER_W'(divisor_i), dvs_neg));

`ifdef DIV_EARLY_OUT_EN
  localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;
  logic ovf_in;
  assign ovf_in    = signed_op && (dividend_i == MIN_NEG) && (divisor_i == ALL_ONES);
  assign early     = launch && (dz_in || ovf_in);
  // Architectural results: x/0 -> all ones rem x ; MIN/-1 -> MIN rem 0
  assign early_res = dz_in ? (rem_sel_in ? dividend_i : ALL_ONES)
                           : (rem_sel_in ? '0 : MIN_NEG);
`else
  assign early     = 1'b0;
  assign early_res = '0;
`endif

  div_restore_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (rem_nxt),
    .quo_o     (quo_nxt)
  );

  // Divide-by-zero leaves the all-ones quotient unsigned; remainder keeps dividend sign
  assign fin_quo = (qneg_q && !dz_q) ? DATA_WIDTH'(negate(HELPER_W'(quo_nxt))) : quo_nxt;
  assign fin_rem = rneg_q ? DATA_WIDTH'(negate(HELPER_W'(rem_nxt))) : rem_nxt;
  assign fin_res = rem_sel_q ? fin_rem : fin_quo;

  // FSM next state and the valid strobe (flush kills the strobe in DONE)
  always_comb begin
    state_d = state_q;
    valid_o = 1'b0;
    case (state_q)
      IDLE: if (launch) state_d = early ? DONE : CALC;
      CALC: begin
        if (flush_i)              state_d = IDLE;
        else if (cnt_q == '0)     state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        valid_o = !flush_i;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand capture at launch, one restoring step per CALC cycle, result load on last step
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      rem_sel_q <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else if (launch) begin
      cnt_q     <= CNT_LAST;
      rem_q     <= '0;
      quo_q     <= dvd_mag;
      dvs_q     <= dvs_mag;
      rem_sel_q <= rem_sel_in;
      qneg_q    <= dvd_neg ^ dvs_neg;
      rneg_q    <= dvd_neg;
      dz_q      <= dz_in;
      if (early) result_q <= early_res;
    end else if ((state_q == CALC) && !flush_i) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      cnt_q <= cnt_q - CNT_WIDTH'(1);
      if (cnt_q == '0) result_q <= fin_res;
    end
  end

  assign result_o = result_q;
  assign busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_exu_div_iter.sv
// Directed self-checking bench for exu_div_iter.
module tb_exu_div_iter;

  localparam logic [3:0] OP_DIV_V  = 4'b0001;
  localparam logic [3:0] OP_DIVU_V = 4'b0010;
  localparam logic [3:0] OP_REM_V  = 4'b0100;
  localparam logic [3:0] OP_REMU_V = 4'b1000;

  localparam int LAT = 33;
`ifdef DIV_EARLY_OUT_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [3:0]  op_i;
  logic        flush_i;
  logic [31:0] result_o;
  logic        busy_o;
  logic        valid_o;

  int n_checks = 0;
  int n_fail   = 0;

  exu_div_iter dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .op_i       (op_i),
    .flush_i    (flush_i),
    .result_o   (result_o),
    .busy_o     (busy_o),
    .valid_o    (valid_o)
  );

  always #5 clk = ~clk;

  task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    op_i       = op;
    dividend_i = a;
    divisor_i  = b;
    start_i    = 1'b1;
  endtask

  // Consumes the launch edge, then observes 40 cycles (T+1..T+40)
  task automatic collect(output logic [31:0] res, output int nvalid,
                         output int vcyc, output int nbusy);
    res = '0; nvalid = 0; vcyc = -1; nbusy = 0;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (valid_o) begin
        nvalid++;
        vcyc = k;
        res  = result_o;
      end
      if (busy_o) nbusy++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = '0;
    dividend_i = '0; divisor_i = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (result_o !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want %h", result_o, 32'h0); end
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_o); end
    n_checks++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_o); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Unsigned, signed and special-case vectors: result, single strobe, latency, busy span
  task automatic run_table(input string grp, input int n, input logic [3:0] ops [0:3],
                           input logic [31:0] as [0:3], input logic [31:0] bs [0:3],
                           input logic [31:0] exps [0:3], input int lats [0:3]);
    logic [31:0] res;
    int nv, vc, nb;
    for (int i = 0; i < n; i++) begin
      launch(ops[i], as[i], bs[i]);
      collect(res, nv, vc, nb);
      n_checks++;
      if (res !== exps[i]) begin n_fail++; $display("FAIL %s[%0d] result got %h want %h", grp, i, res, exps[i]); end
      n_checks++;
      if (nv != 1) begin n_fail++; $display("FAIL %s[%0d] valid_count got %0d want 1", grp, i, nv); end
      n_checks++;
      if (vc != lats[i]) begin n_fail++; $display("FAIL %s[%0d] valid_cycle got %0d want %0d", grp, i, vc, lats[i]); end
      n_checks++;
      if (nb != lats[i]) begin n_fail++; $display("FAIL %s[%0d] busy_cycles got %0d want %0d", grp, i, nb, lats[i]); end
    end
  endtask

  task automatic test_unsigned();
    logic [3:0]  ops [0:3];
    logic [31:0] as [0:3], bs [0:3], exps [0:3];
    int lats [0:3];
    ops  = '{OP_DIVU_V, OP_REMU_V, OP_DIVU_V, OP_REMU_V};
    as   = '{32'd100, 32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    bs   = '{32'd7, 32'd7, 32'd16, 32'd16};
    exps = '{32'd14, 32'd2, 32'h0FFF_FFFF, 32'd15};
    lats = '{LAT, LAT, LAT, LAT};
    run_table("unsigned", 4, ops, as, bs, exps, lats);
  endtask

  task automatic test_signed();
    logic [3:0]  ops [0:3];
    logic [31:0] as [0:3], bs [0:3], exps [0:3];
    int lats [0:3];
    ops  = '{OP_DIV_V, OP_REM_V, OP_REM_V, OP_DIV_V};
    as   = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7};
    bs   = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    exps = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFD};
    lats = '{LAT, LAT, LAT, LAT};
    run_table("signed", 4, ops, as, bs, exps, lats);
  endtask

  task automatic test_special();
    logic [3:0]  ops [0:3];
    logic [31:0] as [0:3], bs [0:3], exps [0:3];
    int lats [0:3];
    ops  = '{OP_DIV_V, OP_REM_V, OP_DIV_V, OP_REM_V};
    as   = '{32'd5, 32'hFFFF_FFFB, 32'h8000_0000, 32'h8000_0000};
    bs   = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    exps = '{32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'h8000_0000, 32'h0};
    lats = '{SPEC_LAT, SPEC_LAT, SPEC_LAT, SPEC_LAT};
    run_table("special", 4, ops, as, bs, exps, lats);
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    int nv, vc;
    logic b34, b35;
    nv = 0; vc = -1; res = '0; b34 = 1'bx; b35 = 1'bx;
    launch(OP_DIVU_V, 32'd100, 32'd7);
    @(posedge clk); #1;
    for (int k = 1; k <= 40; k++) begin
      if (valid_o) begin nv++; vc = k; res = result_o; end
      if (k == 34) b34 = busy_o;
      if (k == 35) b35 = busy_o;
      dividend_i = 32'd200 + 32'(k);
      divisor_i  = 32'd5;
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    n_checks++;
    if (nv != 1) begin n_fail++; $display("FAIL b2b valid_count got %0d want 1", nv); end
    n_checks++;
    if (vc != LAT) begin n_fail++; $display("FAIL b2b valid_cycle got %0d want %0d", vc, LAT); end
    n_checks++;
    if (res !== 32'd14) begin n_fail++; $display("FAIL b2b result got %h want %h", res, 32'd14); end
    n_checks++;
    if (b34 !== 1'b0) begin n_fail++; $display("FAIL b2b busy_T34 got %b want 0", b34); end
    n_checks++;
    if (b35 !== 1'b1) begin n_fail++; $display("FAIL b2b relaunch_busy_T35 got %b want 1", b35); end
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL b2b busy_after_flush got %b want 0", busy_o); end
  endtask

  task automatic test_flush();
    logic [31:0] res;
    int nv, vc, nb, pre_v;
    pre_v = 0;
    launch(OP_DIVU_V, 32'd100, 32'd7);
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (valid_o) pre_v++;
      @(posedge clk); #1;
    end
    if (valid_o) pre_v++;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL flush busy_T11 got %b want 0", busy_o); end
    n_checks++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL flush valid_T11 got %b want 0", valid_o); end
    n_checks++;
    if (pre_v != 0) begin n_fail++; $display("FAIL flush early_valid got %0d want 0", pre_v); end
    launch(OP_DIVU_V, 32'd9, 32'd3);
    collect(res, nv, vc, nb);
    n_checks++;
    if (res !== 32'd3) begin n_fail++; $display("FAIL flush relaunch_result got %h want %h", res, 32'd3); end
    n_checks++;
    if (vc != LAT) begin n_fail++; $display("FAIL flush relaunch_cycle got %0d want %0d", vc, LAT); end
  endtask

  task automatic test_rst_mid();
    int nb, nv;
    launch(OP_DIVU_V, 32'd100, 32'd7);
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    n_checks++;
    if (busy_o !== 1'b1) begin n_fail++; $display("FAIL rst busy_T20 got %b want 1", busy_o); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst busy got %b want 0", busy_o); end
    n_checks++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rst valid got %b want 0", valid_o); end
    n_checks++;
    if (result_o !== 32'h0) begin n_fail++; $display("FAIL rst result got %h want %h", result_o, 32'h0); end
    // Non-one-hot op is not a launch
    launch(4'b0011, 32'd50, 32'd5);
    nb = 0; nv = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (busy_o) nb++;
      if (valid_o) nv++;
    end
    start_i = 1'b0;
    n_checks++;
    if (nb != 0) begin n_fail++; $display("FAIL bad_op busy_cycles got %0d want 0", nb); end
    n_checks++;
    if (nv != 0) begin n_fail++; $display("FAIL bad_op valid_count got %0d want 0", nv); end
    // Flush together with start in IDLE blocks the launch
    launch(OP_DIVU_V, 32'd50, 32'd5);
    flush_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    flush_i = 1'b0;
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_start busy got %b want 0", busy_o); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_back_to_back();
    test_flush();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
